usart_frame_tx: RTL

USART_FRAME_TX -- requirements
Module: usart_frame_tx

---
 rtl/usart_frame_tx.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/usart_frame_tx.sv
// UART frame transmitter. Sends HEADER, addr, mode, the payload bytes
// (most significant byte first) and an optional additive checksum, each
// as an 8N1 character followed by an optional idle gap.
module usart_frame_tx #(
  parameter int unsigned BPS_CNT    = 434,
  parameter int unsigned DATA_BYTES = 3,
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter int unsigned CHK_EN     = 1,
  parameter int unsigned GAP_BITS   = 0
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    start,
  input  logic [7:0]              addr,
  input  logic [7:0]              mode,
  input  logic [8*DATA_BYTES-1:0] D,
  output logic                    uart_txd,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned NBYTES  = 3 + DATA_BYTES + ((CHK_EN != 0) ? 1 : 0);
  // The checksum slot always exists so that no slice depends on CHK_EN.
  localparam int unsigned SLOTS   = 4 + DATA_BYTES;
  localparam int unsigned FRAME_W = 8 * SLOTS;
  localparam int unsigned BPS_W   = 16;
  localparam int unsigned GAP_W   = 4;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP, DONE} state_t;

  state_t             r_state;
  logic [BPS_W-1:0]   r_bps;
  logic [2:0]         r_bit;
  logic [GAP_W-1:0]   r_gap;
  logic [IDX_W-1:0]   r_byte;
  logic [FRAME_W-1:0] r_frame;
  logic               r_txd;
  logic               r_busy;
  logic               r_done;

  state_t             w_state_nxt;
  logic [BPS_W-1:0]   w_bps_nxt;
  logic [BPS_W-1:0]   w_bps_step;
  logic [2:0]         w_bit_nxt;
  logic [GAP_W-1:0]   w_gap_nxt;
  logic [IDX_W-1:0]   w_byte_nxt;
  logic               w_load;
  logic               w_bit_end;
  logic               w_last_byte;
  logic [7:0]         w_chk;
  logic [FRAME_W-1:0] w_frame_load;
  logic [7:0]         w_cur_byte;
  logic               w_txd_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  // Frame image captured at acceptance: slot 0 is the header, then addr, mode, payload, checksum.
  always_comb begin
    w_chk        = addr + mode;
    w_frame_load = '0;
    for (int unsigned k = 0; k < DATA_BYTES; k++) begin
      w_chk = w_chk + D[k*8 +: 8];
    end
    w_frame_load[7:0]   = HEADER;
    w_frame_load[15:8]  = addr;
    w_frame_load[23:16] = mode;
    for (int unsigned k = 0; k < DATA_BYTES; k++) begin
      w_frame_load[(3+k)*8 +: 8] = D[(DATA_BYTES-1-k)*8 +: 8];
    end
    w_frame_load[(3+DATA_BYTES)*8 +: 8] = w_chk;
  end

  assign w_bit_end   = (r_bps == BPS_W'(BPS_CNT - 1));
  assign w_last_byte = (r_byte == IDX_W'(NBYTES - 1));
  assign w_bps_step  = w_bit_end ? '0 : r_bps + BPS_W'(1);

  // Next-state, counter and registered-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_bps_nxt   = r_bps;
    w_bit_nxt   = r_bit;
    w_gap_nxt   = r_gap;
    w_byte_nxt  = r_byte;
    w_load      = 1'b0;
    w_cur_byte  = '0;
    w_txd_nxt   = 1'b1;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        w_bps_nxt  = '0;
        w_bit_nxt  = '0;
        w_gap_nxt  = '0;
        w_byte_nxt = '0;
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        w_bps_nxt = w_bps_step;
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_bit_nxt   = '0;
        end
      end
      DATA: begin
        w_bps_nxt = w_bps_step;
        if (w_bit_end) begin
          if (r_bit == 3'd7) w_state_nxt = STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end
      end
      STOP: begin
        w_bps_nxt = w_bps_step;
        if (w_bit_end) begin
          if (GAP_BITS != 0) begin
            w_state_nxt = GAP;
            w_gap_nxt   = '0;
          end else if (w_last_byte) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = START;
            w_byte_nxt  = r_byte + IDX_W'(1);
          end
        end
      end
      GAP: begin
        w_bps_nxt = w_bps_step;
        if (w_bit_end) begin
          if (r_gap != GAP_W'(GAP_BITS - 1)) begin
            w_gap_nxt = r_gap + GAP_W'(1);
          end else if (w_last_byte) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = START;
            w_byte_nxt  = r_byte + IDX_W'(1);
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_bps_nxt   = '0;
        w_bit_nxt   = '0;
        w_gap_nxt   = '0;
        w_byte_nxt  = '0;
      end
      default: w_state_nxt = IDLE;
    endcase

    for (int unsigned s = 0; s < SLOTS; s++) begin
      if (w_byte_nxt == IDX_W'(s)) w_cur_byte = r_frame[s*8 +: 8];
    end

    case (w_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = w_cur_byte[w_bit_nxt];
      default: w_txd_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt == START) || (w_state_nxt == DATA) ||
                 (w_state_nxt == STOP)  || (w_state_nxt == GAP);
    w_done_nxt = (w_state_nxt == DONE);
  end

  // State, counters and line outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_bps   <= '0;
      r_bit   <= '0;
      r_gap   <= '0;
      r_byte  <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bps   <= w_bps_nxt;
      r_bit   <= w_bit_nxt;
      r_gap   <= w_gap_nxt;
      r_byte  <= w_byte_nxt;
      r_txd   <= w_txd_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Frame image register, loaded only on an accepted start.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)     r_frame <= '0;
    else if (w_load) r_frame <= w_frame_load;
  end

  assign uart_txd = r_txd;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
